// File: rtl/spi_tx_master.sv
// SPI mode-0 byte transmitter with two chip selects, per-frame CS setup/hold/gap timing
// and full-duplex capture of MISO into rx_data.
module spi_tx_master #(
    parameter int unsigned CLK_DIV  = 50,
    parameter int unsigned CS_SETUP = 10,
    parameter int unsigned CS_HOLD  = 10,
    parameter int unsigned CS_GAP   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       tx_cs,
    output logic       tx_ready,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic [1:0] SSEL,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, BIT_LO, BIT_HI, WAIT_BYTE, HOLD, GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         tx_sr_q, tx_sr_d;   // bits still to send after the one on MOSI
    logic [7:0]         rx_sr_q, rx_sr_d;
    logic               last_q, last_d;
    logic               sck_d, mosi_d, rx_valid_d, busy_d;
    logic [1:0]         ssel_d;
    logic [7:0]         rx_data_d;
    logic               accept;

    assign tx_ready = !reset && (state_q == IDLE || state_q == WAIT_BYTE);
    assign accept   = tx_valid && tx_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_sr_q  <= '0;
            rx_sr_q  <= '0;
            last_q   <= 1'b0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            SSEL     <= 2'b11;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_sr_q  <= tx_sr_d;
            rx_sr_q  <= rx_sr_d;
            last_q   <= last_d;
            SCK      <= sck_d;
            MOSI     <= mosi_d;
            SSEL     <= ssel_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            busy     <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        last_d     = last_q;
        sck_d      = SCK;
        mosi_d     = MOSI;
        ssel_d     = SSEL;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sr_d = tx_data[6:0];
                    mosi_d  = tx_data[7];
                    last_d  = tx_last;
                    ssel_d  = tx_cs ? 2'b01 : 2'b10;
                    bit_d   = 3'd0;
                    cnt_d   = CNT_W'(CS_SETUP - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = BIT_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIT_LO: begin
                if (cnt_q == '0) begin
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[6:0], MISO};
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = BIT_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIT_HI: begin
                if (cnt_q == '0) begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        bit_d      = 3'd0;
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        if (last_q) begin
                            cnt_d   = CNT_W'(CS_HOLD - 1);
                            state_d = HOLD;
                        end else begin
                            state_d = WAIT_BYTE;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        cnt_d   = CNT_W'(CLK_DIV - 1);
                        state_d = BIT_LO;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_BYTE: begin
                // chip select stays asserted; tx_cs is ignored mid-frame
                if (accept) begin
                    tx_sr_d = tx_data[6:0];
                    mosi_d  = tx_data[7];
                    last_d  = tx_last;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = BIT_LO;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    ssel_d  = 2'b11;
                    mosi_d  = 1'b0;
                    cnt_d   = CNT_W'(CS_GAP - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                ssel_d  = 2'b11;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master with MISO looped back to MOSI.
module tb_spi_tx_master;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_cs;
    logic       tx_ready, SCK, MOSI, MISO, rx_valid, busy;
    logic [1:0] SSEL;
    logic [7:0] rx_data;

    int pass_cnt = 0;
    int total    = 0;

    spi_tx_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_cs(tx_cs), .tx_ready(tx_ready), .SCK(SCK),
        .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    assign MISO = MOSI;
    always #5 clk = ~clk;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge, away from the active edge
    int          rise_cnt = 0;
    logic [23:0] mosi_bits = '0;
    logic [7:0]  rx_q[$];
    logic [1:0]  ssel_low_seen = '0;
    int          ssel00 = 0;
    int          last_fall_cyc = 0, ssel_rise_cyc = 0;
    logic        sck_prev = 1'b0;
    logic [1:0]  ssel_prev = 2'b11;

    always @(negedge clk) begin
        if (SCK === 1'b1 && sck_prev === 1'b0) begin
            rise_cnt  <= rise_cnt + 1;
            mosi_bits <= {mosi_bits[22:0], MOSI};
        end
        if (SCK === 1'b0 && sck_prev === 1'b1) last_fall_cyc <= cyc;
        if (SSEL === 2'b11 && ssel_prev !== 2'b11) ssel_rise_cyc <= cyc;
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (SSEL === 2'b00) ssel00 <= ssel00 + 1;
        if (SSEL !== 2'bxx) ssel_low_seen <= ssel_low_seen | ~SSEL;
        sck_prev  <= SCK;
        ssel_prev <= SSEL;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        @(posedge clk);
        rise_cnt = 0;
        mosi_bits = '0;
        rx_q.delete();
        ssel_low_seen = '0;
        #1;
    endtask

    // Offer one byte, wait (bounded) for tx_ready, return in the cycle after accept
    task automatic send_byte(input logic [7:0] d, input logic last, input logic cs);
        int n;
        tx_data  = d;
        tx_last  = last;
        tx_cs    = cs;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) $display("FAIL send_timeout: tx_ready=%b required 1", tx_ready);
        else pass_cnt++;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~d;
        tx_last  = ~last;
        tx_cs    = ~cs;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", busy);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; tx_cs = 1'b0;
        tick(); tick();
        total++;
        if ({SSEL, SCK, MOSI, tx_ready, busy, rx_valid, rx_data} !== {2'b11, 5'b00000, 8'h00})
            $display("FAIL reset_state: SSEL=%b SCK=%b MOSI=%b rdy=%b busy=%b rxv=%b rxd=%h required 11 0 0 0 0 0 00",
                     SSEL, SCK, MOSI, tx_ready, busy, rx_valid, rx_data);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total++;
        if (tx_ready !== 1'b1) $display("FAIL idle_ready: tx_ready=%b required 1", tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int c;
        clear_mon();
        send_byte(8'hAA, 1'b1, 1'b0);
        total++;
        if (SSEL !== 2'b10 || MOSI !== 1'b1)
            $display("FAIL single_start: SSEL=%b MOSI=%b required 10 1", SSEL, MOSI);
        else pass_cnt++;
        c = 1;
        while (SCK !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        total++;
        if (c != 5) $display("FAIL first_rise: cycle=%0d required 5", c);
        else pass_cnt++;
        wait_idle();
        total++;
        if (rise_cnt != 8 || mosi_bits[7:0] !== 8'hAA)
            $display("FAIL single_bits: rises=%0d mosi=%h required 8 aa", rise_cnt, mosi_bits[7:0]);
        else pass_cnt++;
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAA)
            $display("FAIL single_rx: count=%0d first=%h required 1 aa", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
        else pass_cnt++;
        total++;
        if (ssel_low_seen !== 2'b01 || SSEL !== 2'b11)
            $display("FAIL single_ssel: low_seen=%b SSEL=%b required 01 11", ssel_low_seen, SSEL);
        else pass_cnt++;
    endtask

    task automatic test_multi_byte();
        int n, bad;
        clear_mon();
        send_byte(8'hAA, 1'b0, 1'b1);
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (SCK !== 1'b0 || SSEL !== 2'b01 || tx_ready !== 1'b1) bad++;
            tick();
        end
        total++;
        if (bad != 0) $display("FAIL wait_byte_stall: bad_cycles=%0d required 0", bad);
        else pass_cnt++;
        send_byte(8'h55, 1'b0, 1'b0);
        total++;
        if (SSEL !== 2'b01 || MOSI !== 1'b0)
            $display("FAIL resume: SSEL=%b MOSI=%b required 01 0", SSEL, MOSI);
        else pass_cnt++;
        send_byte(8'h00, 1'b1, 1'b0);
        wait_idle();
        total++;
        if (rise_cnt != 24 || mosi_bits !== 24'hAA5500)
            $display("FAIL multi_bits: rises=%0d mosi=%h required 24 aa5500", rise_cnt, mosi_bits);
        else pass_cnt++;
        total++;
        if (rx_q.size() != 3 || {rx_q[0], rx_q[1], rx_q[2]} !== 24'hAA5500)
            $display("FAIL multi_rx: count=%0d required 3 aa 55 00", rx_q.size());
        else pass_cnt++;
        total++;
        if (ssel_low_seen !== 2'b10)
            $display("FAIL multi_cs: low_seen=%b required 10", ssel_low_seen);
        else pass_cnt++;
        total++;
        if (ssel_rise_cyc - last_fall_cyc != 2)
            $display("FAIL cs_hold: cycles=%0d required 2", ssel_rise_cyc - last_fall_cyc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n, ready_busy, acc_cyc;
        clear_mon();
        send_byte(8'h3C, 1'b1, 1'b0);
        tx_data = 8'hC3; tx_last = 1'b1; tx_cs = 1'b1; tx_valid = 1'b1;
        n = 0; ready_busy = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (tx_ready === 1'b1 && busy === 1'b1) ready_busy++;
        end
        acc_cyc = cyc;
        tick();
        tx_valid = 1'b0;
        total++;
        if (acc_cyc - ssel_rise_cyc != 4)
            $display("FAIL cs_gap: accept_after_rise=%0d required 4", acc_cyc - ssel_rise_cyc);
        else pass_cnt++;
        total++;
        if (ready_busy != 0) $display("FAIL ready_in_hold_gap: cycles=%0d required 0", ready_busy);
        else pass_cnt++;
        total++;
        if (SSEL !== 2'b01) $display("FAIL b2b_cs: SSEL=%b required 01", SSEL);
        else pass_cnt++;
        wait_idle();
        total++;
        if (rx_q.size() != 2 || {rx_q[0], rx_q[1]} !== 16'h3CC3)
            $display("FAIL b2b_rx: count=%0d required 2 3c c3", rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, rises;
        logic prev;
        clear_mon();
        send_byte(8'hF0, 1'b1, 1'b0);
        n = 0; rises = 0; prev = SCK;
        while (rises < 3 && n < 200) begin
            tick();
            n++;
            if (SCK === 1'b1 && prev === 1'b0) rises++;
            prev = SCK;
        end
        reset = 1'b1;
        tick();
        total++;
        if ({SSEL, SCK, MOSI, busy, rx_valid} !== 6'b110000)
            $display("FAIL mid_reset: SSEL=%b SCK=%b MOSI=%b busy=%b rxv=%b required 11 0 0 0 0",
                     SSEL, SCK, MOSI, busy, rx_valid);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        total++;
        if (rise_cnt != 3 || rx_q.size() != 0 || busy !== 1'b0)
            $display("FAIL mid_reset_abort: rises=%0d rx=%0d busy=%b required 3 0 0", rise_cnt, rx_q.size(), busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_byte();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (ssel00 != 0) $display("FAIL ssel_both_low: cycles=%0d required 0", ssel00);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/spi_tx_master.md
SPI_TX_MASTER -- requirements
Module: spi_tx_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: SCK half-period in clk cycles, legal values >=1.
REQ-002 SHALL have parameter CS_SETUP, default 10: clk cycles from SSEL fall to the start of the first bit, legal values >=1.
REQ-003 SHALL have parameter CS_HOLD, default 10: clk cycles from the last SCK fall to SSEL rise, legal values >=1.
REQ-004 SHALL have parameter CS_GAP, default 20: minimum clk cycles with SSEL high between frames, legal values >=1.
REQ-005 SHALL have port clk  in  1  system clock; one clock only; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port tx_data  in  8  byte to send, MSB first.
REQ-008 SHALL have port tx_valid  in  1  tx_data is valid.
REQ-009 SHALL have port tx_last  in  1  the byte is the final byte of its frame.
REQ-010 SHALL have port tx_cs  in  1  slave select: 0 selects SSEL0, 1 selects SSEL1; sampled only on the first byte of a frame.
REQ-011 SHALL have port tx_ready  out  1  block accepts a byte this cycle.
REQ-012 SHALL have port SCK  out  1  SPI clock.
REQ-013 SHALL have port MOSI  out  1  serial data out.
REQ-014 SHALL have port MISO  in  1  serial data in.
REQ-015 SHALL have port SSEL  out  2  active-low selects {SSEL1, SSEL0}.
REQ-016 SHALL have port rx_data  out  8  byte captured from MISO.
REQ-017 SHALL have port rx_valid  out  1  one-cycle strobe; rx_data is new.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement SPI mode 0: SCK idles low, slave samples on the SCK rise, MOSI changes only while SCK is low, bits sent MSB first.
REQ-020 SHALL use the states IDLE, SETUP, BIT_LO, BIT_HI, WAIT_BYTE, HOLD and GAP.
REQ-021 SHALL drive tx_ready high only in IDLE and WAIT_BYTE, decoded from the state register, and low while reset is high; a byte is accepted when tx_valid and tx_ready are both high.
REQ-022 IDLE plus accept: SHALL latch tx_data, tx_last and tx_cs, then enter SETUP; in the next cycle the selected SSEL bit SHALL be 0 and MOSI SHALL equal bit 7.
REQ-023 SETUP SHALL last CS_SETUP cycles with SCK=0, then enter BIT_LO.
REQ-024 BIT_LO SHALL last CLK_DIV cycles with SCK=0; BIT_HI SHALL last CLK_DIV cycles with SCK=1.
REQ-025 With accept at cycle 0, the first SCK rise SHALL occur at cycle 1+CS_SETUP+CLK_DIV.
REQ-026 MISO SHALL be shifted into the rx shift register, MSB first, on the cycle SCK goes 0->1.
REQ-027 On each BIT_HI->BIT_LO transition SCK SHALL fall and MOSI SHALL advance to the next bit in the same cycle.
REQ-028 After the 8th BIT_HI: SCK SHALL fall, rx_data SHALL update and rx_valid SHALL pulse for 1 cycle.
REQ-029 After the 8th BIT_HI the state SHALL go to HOLD if the latched tx_last=1, else to WAIT_BYTE.
REQ-030 WAIT_BYTE SHALL keep SSEL asserted and SCK=0 and SHALL wait indefinitely.
REQ-031 WAIT_BYTE plus accept: SHALL latch tx_data and tx_last, ignore tx_cs, load MOSI with bit 7 next cycle, and enter BIT_LO with no SETUP.
REQ-032 HOLD SHALL last CS_HOLD cycles with SCK=0, then set SSEL=2'b11 and enter GAP.
REQ-033 GAP SHALL last CS_GAP cycles, then enter IDLE; no byte SHALL be accepted during GAP.
REQ-034 Exactly one SSEL bit SHALL be low during a frame; SSEL SHALL never be 2'b00.
REQ-035 The bit counter SHALL be 3 bits and wrap 7->0 only at a byte end.
REQ-036 The timing counter SHALL be wide enough for max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) without overflow.
REQ-037 In IDLE, SCK SHALL be 0, MOSI SHALL be 0 and SSEL SHALL be 2'b11.
REQ-038 tx_data, tx_last and tx_cs changes SHALL have no effect outside an accept cycle.

Reset
REQ-039 While reset is high, the state SHALL be IDLE and SSEL=2'b11, SCK=0, MOSI=0, tx_ready=0, busy=0, rx_valid=0, rx_data=8'h00 on the next edge.
REQ-040 A reset mid-frame SHALL abort the frame immediately: no further SCK edges, no rx_valid, and the partial byte discarded.

Verification (CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=4; MISO looped to MOSI)
REQ-041 Send 8'hAA with tx_last=1, tx_cs=0 -> SSEL=2'b10; 8 rises with MOSI 1,0,1,0,1,0,1,0; first rise at cycle 5; rx_data=8'hAA with one rx_valid; SSEL1 stays high.
REQ-042 Send 8'hAA, 8'h55, 8'h00 on tx_cs=1, last byte with tx_last=1 -> SSEL=2'b01 continuous; 24 rises; rx_valid values AA, 55, 00; SSEL rises 2 cycles after the last SCK fall.
REQ-043 Hold tx_valid low for 20 cycles between the 1st and 2nd bytes -> SCK stays 0, SSEL stays low, tx_ready=1 throughout, and the frame resumes correctly.
REQ-044 Assert reset after the 3rd SCK rise -> next cycle SSEL=2'b11, SCK=0, MOSI=0, busy=0, with no rx_valid.
REQ-045 Offer back-to-back frames -> the second accept occurs no earlier than 4 cycles after the SSEL rise; tx_ready=0 in HOLD and GAP.
REQ-046 Change tx_cs on the 2nd byte of a frame -> the active SSEL bit does not change.
